// File: rtl/icache_inv_queue_pkg.sv
// Shared types and configuration for the instruction-invalidation queue.
package icache_inv_queue_pkg;

    localparam int unsigned INV_QUEUE_DEPTH = 4;
    localparam int unsigned INV_ADDR_W      = 30;

    typedef logic [INV_ADDR_W-1:0] inv_word_addr_t;

    typedef enum logic {
        INVQ_IDLE,
        INVQ_ISSUED
    } inv_queue_state_t;

endpackage

// File: rtl/icache_inv_queue_fifo.sv
// Address FIFO for the invalidation queue: storage, wrapping pointers and occupancy count.
module icache_inv_queue_fifo
    import icache_inv_queue_pkg::*;
#(
    parameter int unsigned DEPTH = INV_QUEUE_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push_i,
    input  inv_word_addr_t push_addr_i,
    input  logic           pop_i,
    output logic           full_o,
    output logic           empty_o,
    output logic           one_left_o,
    output inv_word_addr_t head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    inv_word_addr_t   mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_i) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wptr_q] <= push_addr_i;
        end
    end

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign one_left_o = (count_q == CNT_W'(1));
    assign head_o     = mem_q[rptr_q];

endmodule

// File: rtl/icache_inv_queue.sv
// Buffers i-cache invalidations and re-issues them one at a time until the consumer completes each.
// Optional ICACHE_INV_QUEUE_COALESCE_EN drops a request repeating the still-unissued tail address.
module icache_inv_queue
    import icache_inv_queue_pkg::*;
#(
    parameter int unsigned DEPTH = INV_QUEUE_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] up_inv_addr,
    input  logic        up_inv_valid,
    output logic        up_inv_ready,
    output logic        up_inv_outstanding,
    output logic [29:0] dn_inv_addr,
    output logic        dn_inv_valid,
    input  logic        dn_inv_completed
);

    inv_queue_state_t state_q;
    inv_word_addr_t   dn_addr_q;
    logic             dn_valid_q;

    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_one_left;
    inv_word_addr_t fifo_head;
    logic           accept;
    logic           push;
    logic           pop;
    logic           issue;

    assign accept = up_inv_valid && up_inv_ready;
    assign issue  = (state_q == INVQ_IDLE) && !fifo_empty;
    assign pop    = (state_q == INVQ_ISSUED) && dn_inv_completed;

`ifdef ICACHE_INV_QUEUE_COALESCE_EN
    logic           tail_valid_q;
    inv_word_addr_t tail_addr_q;

    // Tail is only a coalescing target while it is queued but not yet handed downstream.
    assign push = accept && !(tail_valid_q && (up_inv_addr == tail_addr_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            tail_valid_q <= 1'b0;
            tail_addr_q  <= '0;
        end else if (push) begin
            tail_valid_q <= 1'b1;
            tail_addr_q  <= up_inv_addr;
        end else if ((issue || pop) && fifo_one_left) begin
            tail_valid_q <= 1'b0;
        end
    end
`else
    logic unused_one_left;

    assign push            = accept;
    assign unused_one_left = fifo_one_left;
`endif

    icache_inv_queue_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_addr_i(up_inv_addr),
        .pop_i      (pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .one_left_o (fifo_one_left),
        .head_o     (fifo_head)
    );

    // Issue FSM: head stays resident until completion, forcing one idle cycle between issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INVQ_IDLE;
            dn_valid_q <= 1'b0;
            dn_addr_q  <= '0;
        end else begin
            case (state_q)
                INVQ_IDLE: begin
                    if (!fifo_empty) begin
                        dn_addr_q  <= fifo_head;
                        dn_valid_q <= 1'b1;
                        state_q    <= INVQ_ISSUED;
                    end
                end
                INVQ_ISSUED: begin
                    if (dn_inv_completed) begin
                        dn_valid_q <= 1'b0;
                        state_q    <= INVQ_IDLE;
                    end
                end
            endcase
        end
    end

    assign up_inv_ready       = !fifo_full;
    assign up_inv_outstanding = !fifo_empty;
    assign dn_inv_addr        = dn_addr_q;
    assign dn_inv_valid       = dn_valid_q;

`ifndef SYNTHESIS
    a_no_idle_completion: assert property (@(posedge clk) disable iff (rst)
        !(dn_inv_completed && (state_q == INVQ_IDLE)));
`endif

endmodule

// File: tb/tb_icache_inv_queue.sv
// Bench for icache_inv_queue: queue-based reference model compared every cycle, plus directed literal checks.
module tb_icache_inv_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] up_inv_addr;
    logic        up_inv_valid;
    logic        up_inv_ready;
    logic        up_inv_outstanding;
    logic [29:0] dn_inv_addr;
    logic        dn_inv_valid;
    logic        dn_inv_completed;

    always #5 clk = ~clk;

    icache_inv_queue #(
        .DEPTH(DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .up_inv_addr       (up_inv_addr),
        .up_inv_valid      (up_inv_valid),
        .up_inv_ready      (up_inv_ready),
        .up_inv_outstanding(up_inv_outstanding),
        .dn_inv_addr       (dn_inv_addr),
        .dn_inv_valid      (dn_inv_valid),
        .dn_inv_completed  (dn_inv_completed)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending addresses in order (head included) and the issue status.
    logic [29:0] mq[$];
    bit          m_issued;
    logic [29:0] m_iss_addr;
    logic [29:0] issue_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit push;
        bit drop;
        bit start;
        if (rst) begin
            mq.delete();
            m_issued = 1'b0;
            return;
        end
        push = up_inv_valid && (mq.size() != DEPTH);
        drop = 1'b0;
`ifdef ICACHE_INV_QUEUE_COALESCE_EN
        if (push && mq.size() > 0 && !(m_issued && mq.size() == 1) && up_inv_addr == mq[$])
            drop = 1'b1;
`endif
        start = !m_issued && (mq.size() != 0);
        if (m_issued && dn_inv_completed) begin
            void'(mq.pop_front());
            m_issued = 1'b0;
        end else if (start) begin
            m_iss_addr = mq[0];
            issue_log.push_back(mq[0]);
            m_issued = 1'b1;
        end
        if (push && !drop) mq.push_back(up_inv_addr);
    endtask

    task automatic compare_model();
        chk("ready", 32'(up_inv_ready), 32'(mq.size() != DEPTH));
        chk("outstanding", 32'(up_inv_outstanding), 32'(mq.size() != 0));
        chk("dn_valid", 32'(dn_inv_valid), 32'(m_issued));
        if (m_issued) chk("dn_addr", 32'(dn_inv_addr), 32'(m_iss_addr));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic push_one(input logic [29:0] a, input bit auto_done);
        bit took = 1'b0;
        up_inv_valid = 1'b1;
        up_inv_addr  = a;
        for (int i = 0; i < 50 && !took; i++) begin
            took = (mq.size() != DEPTH);
            dn_inv_completed = auto_done && m_issued;
            tick();
        end
        up_inv_valid     = 1'b0;
        dn_inv_completed = 1'b0;
        chk("push_accept", 32'(took), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (mq.size() != 0 || m_issued); i++) begin
            dn_inv_completed = m_issued;
            tick();
        end
        dn_inv_completed = 1'b0;
        tick();
        chk("drain_done", 32'(up_inv_outstanding), 32'd0);
    endtask

    logic [29:0] exp_fill [5];

    initial begin
        exp_fill = '{30'h10, 30'h11, 30'h12, 30'h13, 30'h14};
        rst = 1'b1;
        up_inv_valid = 1'b0;
        up_inv_addr = '0;
        dn_inv_completed = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        chk("rst_ready", 32'(up_inv_ready), 32'd1);
        chk("rst_outstanding", 32'(up_inv_outstanding), 32'd0);
        chk("rst_dn_valid", 32'(dn_inv_valid), 32'd0);
        chk("rst_dn_addr", 32'(dn_inv_addr), 32'd0);
        tick();

        // Single request: outstanding after one edge, issued after the next, cleared on completion.
        up_inv_valid = 1'b1;
        up_inv_addr  = 30'h1000;
        tick();
        up_inv_valid = 1'b0;
        chk("single_outstanding", 32'(up_inv_outstanding), 32'd1);
        chk("single_not_yet", 32'(dn_inv_valid), 32'd0);
        tick();
        chk("single_issue", 32'(dn_inv_valid), 32'd1);
        chk("single_addr", 32'(dn_inv_addr), 32'h1000);
        tick();
        tick();
        dn_inv_completed = 1'b1;
        tick();
        dn_inv_completed = 1'b0;
        chk("single_done_valid", 32'(dn_inv_valid), 32'd0);
        chk("single_done_outst", 32'(up_inv_outstanding), 32'd0);
        tick();

        // Fill and backpressure, then full with a completion in the same cycle.
        issue_log.delete();
        for (int i = 0; i < 4; i++) push_one(30'h10 + 30'(i), 1'b0);
        chk("full_ready", 32'(up_inv_ready), 32'd0);
        up_inv_valid = 1'b1;
        up_inv_addr  = 30'h14;
        for (int i = 0; i < 3; i++) tick();
        chk("full_held_ready", 32'(up_inv_ready), 32'd0);
        chk("full_head", 32'(dn_inv_addr), 32'h10);
        dn_inv_completed = 1'b1;
        tick();
        dn_inv_completed = 1'b0;
        chk("full_cpl_ready", 32'(up_inv_ready), 32'd1);
        chk("full_cpl_bubble", 32'(dn_inv_valid), 32'd0);
        tick();
        up_inv_valid = 1'b0;
        chk("full_refill_ready", 32'(up_inv_ready), 32'd0);
        drain();
        chk("fill_count", 32'(issue_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk("fill_order", 32'(issue_log[i]), 32'(exp_fill[i]));

        // Pointer wrap: ten distinct addresses streamed with prompt completion.
        issue_log.delete();
        for (int i = 0; i < 10; i++) push_one(30'h100 + 30'(i), 1'b1);
        drain();
        chk("wrap_count", 32'(issue_log.size()), 32'd10);
        for (int i = 0; i < 10; i++) chk("wrap_order", 32'(issue_log[i]), 32'h100 + 32'(i));

        // Reset mid-operation with entries queued and one in flight.
        for (int i = 0; i < 3; i++) push_one(30'h30 + 30'(i), 1'b0);
        chk("midrst_issued", 32'(dn_inv_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", 32'(dn_inv_valid), 32'd0);
        chk("midrst_outst", 32'(up_inv_outstanding), 32'd0);
        chk("midrst_ready", 32'(up_inv_ready), 32'd1);
        for (int i = 0; i < 3; i++) tick();

`ifdef ICACHE_INV_QUEUE_COALESCE_EN
        // Coalescing: a repeat of the issued head is queued, repeats of an unissued tail are not.
        issue_log.delete();
        push_one(30'h20, 1'b0);
        tick();
        chk("co_head_issued", 32'(dn_inv_valid), 32'd1);
        push_one(30'h20, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("co_ready", 32'(up_inv_ready), 32'd1);
            push_one(30'h21, 1'b0);
        end
        drain();
        chk("co_count", 32'(issue_log.size()), 32'd3);
        chk("co_first", 32'(issue_log[0]), 32'h20);
        chk("co_second", 32'(issue_log[1]), 32'h20);
        chk("co_third", 32'(issue_log[2]), 32'h21);
`endif

        // Randomized traffic over a small address set, with occasional resets.
        for (int i = 0; i < 800; i++) begin
            rst              = ($urandom_range(0, 199) == 0);
            up_inv_valid     = ($urandom_range(0, 2) != 0);
            up_inv_addr      = 30'h40 + 30'($urandom_range(0, 3));
            dn_inv_completed = m_issued && ($urandom_range(0, 2) == 0);
            tick();
        end
        rst = 1'b0;
        up_inv_valid = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
